// File: rtl/uart_rx_fifo.sv
// uart_rx_fifo: oversampling UART receiver feeding a first-word-fall-through FIFO.
//   rx_clk         oversample clock (OVERSAMPLE x baud), single clock domain
//   rx_rst_n       asynchronous active-low reset
//   rx_data        serial line, idles high, asynchronous to rx_clk
//   rx_dout        head-of-FIFO data word, LSB = first received bit
//   rx_parity_err  head-of-FIFO parity error flag (0 when PARITY = 0)
//   rx_frame_err   head-of-FIFO framing error flag
//   rx_valid       FIFO non-empty
//   rx_ready       consumer accepts head entry
//   rx_overrun     one-cycle pulse when a completed word is dropped (FIFO full)
//   rx_busy        receiver is inside a frame
module uart_rx_fifo #(
  parameter int unsigned WIDTH      = 8,
  parameter int unsigned PARITY     = 0,
  parameter int unsigned STOP_BITS  = 1,
  parameter int unsigned OVERSAMPLE = 16,
  parameter int unsigned FIFO_DEPTH = 4
) (
  input  logic             rx_clk,
  input  logic             rx_rst_n,
  input  logic             rx_data,
  output logic [WIDTH-1:0] rx_dout,
  output logic             rx_parity_err,
  output logic             rx_frame_err,
  output logic             rx_valid,
  input  logic             rx_ready,
  output logic             rx_overrun,
  output logic             rx_busy
);

  localparam int unsigned CW = $clog2(OVERSAMPLE);
  localparam int unsigned AW = $clog2(FIFO_DEPTH);
  localparam int unsigned NW = AW + 1;
  localparam int unsigned EW = WIDTH + 2;

  localparam logic [CW-1:0] CNT_LAST = CW'(OVERSAMPLE - 1);
  localparam logic [CW-1:0] CNT_S0   = CW'(OVERSAMPLE / 2 - 1);
  localparam logic [CW-1:0] CNT_S1   = CW'(OVERSAMPLE / 2);
  localparam logic [CW-1:0] CNT_VOTE = CW'(OVERSAMPLE / 2 + 1);
  localparam logic [3:0]    DATA_LAST = 4'(WIDTH - 1);
  localparam logic [3:0]    STOP_LAST = 4'(STOP_BITS - 1);
  localparam logic [NW-1:0] FIFO_FULL = NW'(FIFO_DEPTH);
  localparam bit            HAS_PARITY = (PARITY != 0);
  localparam bit            ODD_PARITY = (PARITY == 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_PARITY,
    S_STOP
  } state_t;

  // Line synchroniser plus one history flop for falling-edge detection
  logic sync_q;
  logic line_sync;
  logic line_prev;

  always_ff @(posedge rx_clk or negedge rx_rst_n) begin
    if (!rx_rst_n) begin
      sync_q    <= 1'b1;
      line_sync <= 1'b1;
      line_prev <= 1'b1;
    end else begin
      sync_q    <= rx_data;
      line_sync <= sync_q;
      line_prev <= line_sync;
    end
  end

  state_t           state_q;
  logic [CW-1:0]    cnt_q;
  logic [3:0]       bit_idx_q;
  logic [WIDTH-1:0] shreg_q;
  logic             samp0_q;
  logic             samp1_q;
  logic             parity_err_q;
  logic             frame_err_q;

  logic start_det_c;
  logic wrap_c;
  logic vote_pt_c;
  logic vote_c;
  logic push_req_c;
  logic [EW-1:0] push_word_c;

  assign start_det_c = (state_q == S_IDLE) && !line_sync && line_prev;
  assign wrap_c      = (cnt_q == CNT_LAST);
  assign vote_pt_c   = (cnt_q == CNT_VOTE);
  // Majority of the two stored samples and the live third sample
  assign vote_c      = (samp0_q & samp1_q) | (samp0_q & line_sync) | (samp1_q & line_sync);
  // Word completes at the vote point of the last stop bit
  assign push_req_c  = (state_q == S_STOP) && vote_pt_c && (bit_idx_q == STOP_LAST);
  assign push_word_c = {frame_err_q | ~vote_c, parity_err_q, shreg_q};

  // Frame FSM with sample counter, shifter and error accumulation
  always_ff @(posedge rx_clk or negedge rx_rst_n) begin
    if (!rx_rst_n) begin
      state_q      <= S_IDLE;
      cnt_q        <= '0;
      bit_idx_q    <= '0;
      shreg_q      <= '0;
      samp0_q      <= 1'b1;
      samp1_q      <= 1'b1;
      parity_err_q <= 1'b0;
      frame_err_q  <= 1'b0;
      rx_busy      <= 1'b0;
    end else begin
      if (state_q != S_IDLE) begin
        cnt_q <= wrap_c ? '0 : cnt_q + CW'(1);
        if (cnt_q == CNT_S0) samp0_q <= line_sync;
        if (cnt_q == CNT_S1) samp1_q <= line_sync;
      end
      case (state_q)
        S_IDLE: begin
          if (start_det_c) begin
            state_q      <= S_START;
            cnt_q        <= '0;
            bit_idx_q    <= '0;
            parity_err_q <= 1'b0;
            frame_err_q  <= 1'b0;
            rx_busy      <= 1'b1;
          end
        end
        S_START: begin
          if (vote_pt_c && vote_c) begin
            // False start: line was high again at mid-bit
            state_q <= S_IDLE;
            cnt_q   <= '0;
            rx_busy <= 1'b0;
          end else if (wrap_c) begin
            state_q   <= S_DATA;
            bit_idx_q <= '0;
          end
        end
        S_DATA: begin
          if (vote_pt_c) shreg_q <= {vote_c, shreg_q[WIDTH-1:1]};
          if (wrap_c) begin
            if (bit_idx_q == DATA_LAST) begin
              state_q   <= HAS_PARITY ? S_PARITY : S_STOP;
              bit_idx_q <= '0;
            end else begin
              bit_idx_q <= bit_idx_q + 4'd1;
            end
          end
        end
        S_PARITY: begin
          if (vote_pt_c) parity_err_q <= (^shreg_q) ^ vote_c ^ ODD_PARITY;
          if (wrap_c) state_q <= S_STOP;
        end
        S_STOP: begin
          if (vote_pt_c && !vote_c) frame_err_q <= 1'b1;
          if (push_req_c) begin
            // Leave early so a start edge in the stop bit's second half is seen
            state_q   <= S_IDLE;
            cnt_q     <= '0;
            bit_idx_q <= '0;
            rx_busy   <= 1'b0;
          end else if (wrap_c) begin
            bit_idx_q <= bit_idx_q + 4'd1;
          end
        end
        default: begin
          state_q <= S_IDLE;
          cnt_q   <= '0;
          rx_busy <= 1'b0;
        end
      endcase
    end
  end

  // FIFO bookkeeping
  logic [EW-1:0] mem_q [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr_q;
  logic [AW-1:0] rd_ptr_q;
  logic [NW-1:0] count_q;
  logic [NW-1:0] count_nxt_c;
  logic          pop_c;
  logic          push_ok_c;
  logic [EW-1:0] head_c;

  assign pop_c     = rx_valid && rx_ready;
  // A simultaneous pop frees the slot the push needs
  assign push_ok_c = push_req_c && ((count_q != FIFO_FULL) || pop_c);

  always_comb begin
    count_nxt_c = count_q;
    if (push_ok_c && !pop_c) count_nxt_c = count_q + NW'(1);
    if (pop_c && !push_ok_c) count_nxt_c = count_q - NW'(1);
  end

  always_ff @(posedge rx_clk or negedge rx_rst_n) begin
    if (!rx_rst_n) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      rx_valid   <= 1'b0;
      rx_overrun <= 1'b0;
    end else begin
      if (push_ok_c) wr_ptr_q <= wr_ptr_q + AW'(1);
      if (pop_c)     rd_ptr_q <= rd_ptr_q + AW'(1);
      count_q    <= count_nxt_c;
      rx_valid   <= (count_nxt_c != '0);
      rx_overrun <= push_req_c && !push_ok_c;
    end
  end

  // Storage needs no reset; reads are gated by rx_valid
  always_ff @(posedge rx_clk) begin
    if (push_ok_c) mem_q[wr_ptr_q] <= push_word_c;
  end

  assign head_c        = mem_q[rd_ptr_q];
  assign rx_dout       = rx_valid ? head_c[WIDTH-1:0] : '0;
  assign rx_parity_err = rx_valid & head_c[WIDTH];
  assign rx_frame_err  = rx_valid & head_c[WIDTH+1];

endmodule

// File: tb/tb_uart_rx_fifo.sv
// tb_uart_rx_fifo: drives two receivers (8N1 and 8E2, OVERSAMPLE 16, depth 4)
// with serial frames and compares the FIFO output to a frame-level model.
module tb_uart_rx_fifo;

  localparam int OS = 16;

  logic clk = 1'b0;
  logic rst_n;
  logic [1:0] line;
  logic [1:0] ready;
  wire  [1:0][7:0] dout;
  wire  [1:0] perr;
  wire  [1:0] ferr;
  wire  [1:0] valid;
  wire  [1:0] ovr;
  wire  [1:0] busy;

  int vectors = 0;
  int miscompares = 0;
  int cyc = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  uart_rx_fifo #(.WIDTH(8), .PARITY(0), .STOP_BITS(1), .OVERSAMPLE(OS), .FIFO_DEPTH(4)) u_n (
    .rx_clk(clk), .rx_rst_n(rst_n), .rx_data(line[0]), .rx_dout(dout[0]),
    .rx_parity_err(perr[0]), .rx_frame_err(ferr[0]), .rx_valid(valid[0]),
    .rx_ready(ready[0]), .rx_overrun(ovr[0]), .rx_busy(busy[0]));

  uart_rx_fifo #(.WIDTH(8), .PARITY(2), .STOP_BITS(2), .OVERSAMPLE(OS), .FIFO_DEPTH(4)) u_e (
    .rx_clk(clk), .rx_rst_n(rst_n), .rx_data(line[1]), .rx_dout(dout[1]),
    .rx_parity_err(perr[1]), .rx_frame_err(ferr[1]), .rx_valid(valid[1]),
    .rx_ready(ready[1]), .rx_overrun(ovr[1]), .rx_busy(busy[1]));

  // Channel 0 is 8N1, channel 1 is 8 data, even parity, 2 stop bits
  function automatic int nstop(input int ch);
    return (ch == 1) ? 2 : 1;
  endfunction

  function automatic int lat_exp(input int ch);
    int p;
    p = (ch == 1) ? 1 : 0;
    return (1 + 8 + p + nstop(ch) - 1) * OS + OS / 2 + 2;
  endfunction

  // Expected {frame_err, parity_err, data} from what was put on the wire
  function automatic logic [9:0] model_word(input int ch, input logic [7:0] d,
                                            input logic pbit, input logic [1:0] stops);
    int ones;
    logic pe;
    logic fe;
    ones = $countones(d) + ((ch == 1 && pbit) ? 1 : 0);
    pe = (ch == 1) && ((ones % 2) != 0);
    fe = (ch == 1) ? (stops != 2'b11) : !stops[0];
    return {fe, pe, d};
  endfunction

  task automatic tick(input int n);
    if (n > 0) begin
      repeat (n) @(posedge clk);
      #1;
    end
  endtask

  task automatic send_frame(input int ch, input logic [7:0] d, input logic pbit,
                            input logic [1:0] stops);
    line[ch] = 1'b0;
    tick(OS);
    for (int i = 0; i < 8; i++) begin
      line[ch] = d[i];
      tick(OS);
    end
    if (ch == 1) begin
      line[ch] = pbit;
      tick(OS);
    end
    for (int i = 0; i < nstop(ch); i++) begin
      line[ch] = stops[i];
      tick(OS);
    end
    line[ch] = 1'b1;
  endtask

  task automatic wait_valid(input int ch, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 40; i++) begin
      if (valid[ch]) begin
        ok = 1'b1;
        break;
      end
      tick(1);
    end
  endtask

  task automatic pop(input int ch);
    ready[ch] = 1'b1;
    tick(1);
    ready[ch] = 1'b0;
  endtask

  // Sends a frame while timing busy-rise to first valid and capturing the head word
  task automatic send_and_time(input int ch, input logic [7:0] d, input logic pbit,
                               input logic [1:0] stops, output int lat, output int vcyc,
                               output logic [9:0] word, output logic busy_at_push);
    int t0;
    t0 = -1;
    lat = -1;
    vcyc = 0;
    word = '0;
    busy_at_push = 1'b1;
    fork
      send_frame(ch, d, pbit, stops);
      begin
        for (int i = 0; i < 12 && t0 < 0; i++) begin
          tick(1);
          if (busy[ch]) t0 = cyc;
        end
        if (t0 >= 0) begin
          for (int i = 0; i < 250; i++) begin
            tick(1);
            if (valid[ch]) begin
              if (vcyc == 0) begin
                lat = cyc - t0;
                word = {ferr[ch], perr[ch], dout[ch]};
                busy_at_push = busy[ch];
              end
              vcyc++;
            end
          end
        end
      end
    join
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    line = 2'b11;
    ready = 2'b00;
    tick(3);
    for (int ch = 0; ch < 2; ch++) begin
      vectors++;
      if ({dout[ch], perr[ch], ferr[ch], valid[ch], ovr[ch], busy[ch]} !== 13'd0) begin
        miscompares++;
        $display("FAIL reset_outputs ch%0d: got %0h want 0", ch,
                 {dout[ch], perr[ch], ferr[ch], valid[ch], ovr[ch], busy[ch]});
      end
    end
    rst_n = 1'b1;
    tick(4);
  endtask

  task automatic test_clean_8n1;
    int lat, vc;
    logic [9:0] w;
    logic bp;
    ready[0] = 1'b1;
    send_and_time(0, 8'hA5, 1'b0, 2'b11, lat, vc, w, bp);
    ready[0] = 1'b0;
    vectors++;
    if (w !== model_word(0, 8'hA5, 1'b0, 2'b11)) begin
      miscompares++;
      $display("FAIL clean_word: got %0h want %0h", w, model_word(0, 8'hA5, 1'b0, 2'b11));
    end
    vectors++;
    if (vc !== 1) begin
      miscompares++;
      $display("FAIL clean_valid_cycles: got %0d want 1", vc);
    end
    vectors++;
    if (lat !== lat_exp(0)) begin
      miscompares++;
      $display("FAIL clean_push_latency: got %0d want %0d", lat, lat_exp(0));
    end
    vectors++;
    if (bp !== 1'b0) begin
      miscompares++;
      $display("FAIL clean_busy_at_push: got %0b want 0", bp);
    end
  endtask

  task automatic test_parity;
    int lat, vc;
    logic [9:0] w;
    logic bp;
    ready[1] = 1'b1;
    for (int k = 0; k < 2; k++) begin
      logic pb;
      pb = (k == 0) ? 1'b1 : 1'b0;
      send_and_time(1, 8'h07, pb, 2'b11, lat, vc, w, bp);
      vectors++;
      if (w !== model_word(1, 8'h07, pb, 2'b11)) begin
        miscompares++;
        $display("FAIL parity_word pbit=%0b: got %0h want %0h", pb, w,
                 model_word(1, 8'h07, pb, 2'b11));
      end
      vectors++;
      if (lat !== lat_exp(1) || vc !== 1) begin
        miscompares++;
        $display("FAIL parity_timing: got lat %0d cycles %0d want lat %0d cycles 1",
                 lat, vc, lat_exp(1));
      end
    end
    ready[1] = 1'b0;
  endtask

  task automatic test_false_start;
    int busy_hi;
    bit vseen;
    busy_hi = 0;
    vseen = 1'b0;
    line[0] = 1'b0;
    for (int i = 0; i < 40; i++) begin
      if (i == 4) line[0] = 1'b1;
      tick(1);
      if (busy[0]) busy_hi++;
      if (valid[0]) vseen = 1'b1;
    end
    vectors++;
    if (busy_hi < 1 || busy_hi > 12 || busy[0] !== 1'b0) begin
      miscompares++;
      $display("FAIL false_start_busy: got %0d busy cycles (final %0b) want 1..12 and final 0",
               busy_hi, busy[0]);
    end
    vectors++;
    if (vseen !== 1'b0) begin
      miscompares++;
      $display("FAIL false_start_valid: got 1 want 0");
    end
  endtask

  task automatic test_frame_err;
    bit ok;
    logic [9:0] w;
    ready = 2'b00;
    fork
      send_frame(0, 8'h3C, 1'b0, 2'b00);
      send_frame(1, 8'h3C, 1'b0, 2'b01);
    join
    for (int ch = 0; ch < 2; ch++) begin
      logic [1:0] st;
      st = (ch == 0) ? 2'b00 : 2'b01;
      wait_valid(ch, ok);
      w = {ferr[ch], perr[ch], dout[ch]};
      vectors++;
      if (!ok || w !== model_word(ch, 8'h3C, 1'b0, st)) begin
        miscompares++;
        $display("FAIL frame_err ch%0d: got %0h (valid %0b) want %0h", ch, w, ok,
                 model_word(ch, 8'h3C, 1'b0, st));
      end
      pop(ch);
    end
  endtask

  task automatic test_break;
    bit ok;
    logic [9:0] w;
    int lat, vc;
    logic bp;
    ready[0] = 1'b0;
    line[0] = 1'b0;
    tick(3 * 10 * OS);
    line[0] = 1'b1;
    tick(20);
    wait_valid(0, ok);
    w = {ferr[0], perr[0], dout[0]};
    vectors++;
    if (!ok || w !== 10'h200) begin
      miscompares++;
      $display("FAIL break_word: got %0h (valid %0b) want 200", w, ok);
    end
    pop(0);
    vectors++;
    if (valid[0] !== 1'b0) begin
      miscompares++;
      $display("FAIL break_single_word: got valid %0b want 0", valid[0]);
    end
    ready[0] = 1'b1;
    send_and_time(0, 8'h55, 1'b0, 2'b11, lat, vc, w, bp);
    ready[0] = 1'b0;
    vectors++;
    if (w !== 10'h055 || vc !== 1) begin
      miscompares++;
      $display("FAIL after_break_word: got %0h cycles %0d want 055 cycles 1", w, vc);
    end
  endtask

  task automatic test_overrun;
    logic [7:0] q[$];
    int ovr_exp, ovr_cnt;
    bit ok;
    ovr_exp = 0;
    ovr_cnt = 0;
    ready[0] = 1'b0;
    for (int i = 1; i <= 5; i++) begin
      if (q.size() < 4) q.push_back(8'(i));
      else ovr_exp++;
    end
    fork
      for (int i = 1; i <= 5; i++) send_frame(0, 8'(i), 1'b0, 2'b11);
      for (int i = 0; i < 5 * 10 * OS + 30; i++) begin
        tick(1);
        if (ovr[0]) ovr_cnt++;
      end
    join
    vectors++;
    if (ovr_cnt !== ovr_exp) begin
      miscompares++;
      $display("FAIL overrun_pulses: got %0d want %0d", ovr_cnt, ovr_exp);
    end
    while (q.size() > 0) begin
      logic [7:0] e;
      e = q.pop_front();
      wait_valid(0, ok);
      vectors++;
      if (!ok || {ferr[0], perr[0], dout[0]} !== {2'b00, e}) begin
        miscompares++;
        $display("FAIL overrun_drain: got %0h (valid %0b) want %0h", dout[0], ok, e);
      end
      pop(0);
    end
    vectors++;
    if (valid[0] !== 1'b0) begin
      miscompares++;
      $display("FAIL overrun_empty: got valid %0b want 0", valid[0]);
    end
  endtask

  task automatic test_full_pop;
    logic [7:0] q[$];
    int ovr_cnt, t0_seen;
    bit ok;
    ovr_cnt = 0;
    t0_seen = 0;
    ready[0] = 1'b0;
    for (int i = 0; i < 4; i++) begin
      q.push_back(8'h11 + 8'(i));
      send_frame(0, 8'h11 + 8'(i), 1'b0, 2'b11);
    end
    // Handshake lands exactly on the push edge: one leaves, the new word enters
    void'(q.pop_front());
    q.push_back(8'h99);
    fork
      send_frame(0, 8'h99, 1'b0, 2'b11);
      begin
        for (int i = 0; i < 12 && t0_seen == 0; i++) begin
          tick(1);
          if (busy[0]) t0_seen = 1;
        end
        tick(lat_exp(0) - 1);
        ready[0] = 1'b1;
        tick(1);
        ready[0] = 1'b0;
      end
      for (int i = 0; i < 10 * OS + 20; i++) begin
        tick(1);
        if (ovr[0]) ovr_cnt++;
      end
    join
    vectors++;
    if (ovr_cnt !== 0 || t0_seen !== 1) begin
      miscompares++;
      $display("FAIL full_pop_overrun: got %0d pulses (start seen %0d) want 0 (1)",
               ovr_cnt, t0_seen);
    end
    while (q.size() > 0) begin
      logic [7:0] e;
      e = q.pop_front();
      wait_valid(0, ok);
      vectors++;
      if (!ok || dout[0] !== e) begin
        miscompares++;
        $display("FAIL full_pop_drain: got %0h (valid %0b) want %0h", dout[0], ok, e);
      end
      pop(0);
    end
    vectors++;
    if (valid[0] !== 1'b0) begin
      miscompares++;
      $display("FAIL full_pop_empty: got valid %0b want 0", valid[0]);
    end
  endtask

  task automatic test_back_to_back;
    logic [9:0] q[$];
    bit ok;
    ready[1] = 1'b0;
    for (int i = 0; i < 3; i++) begin
      logic [7:0] d;
      logic pb;
      d = 8'($urandom);
      pb = 1'($urandom);
      q.push_back(model_word(1, d, pb, 2'b11));
      send_frame(1, d, pb, 2'b11);
    end
    while (q.size() > 0) begin
      logic [9:0] e;
      e = q.pop_front();
      wait_valid(1, ok);
      vectors++;
      if (!ok || {ferr[1], perr[1], dout[1]} !== e) begin
        miscompares++;
        $display("FAIL back_to_back: got %0h (valid %0b) want %0h",
                 {ferr[1], perr[1], dout[1]}, ok, e);
      end
      pop(1);
    end
  endtask

  task automatic test_random;
    bit ok;
    ready = 2'b00;
    for (int ch = 0; ch < 2; ch++) begin
      for (int i = 0; i < 8; i++) begin
        logic [7:0] d;
        logic pb;
        logic [1:0] st;
        logic [9:0] e;
        d = 8'($urandom);
        pb = 1'($urandom);
        st = ($urandom_range(0, 3) == 0) ? 2'($urandom) : 2'b11;
        e = model_word(ch, d, pb, st);
        tick($urandom_range(0, 12));
        send_frame(ch, d, pb, st);
        wait_valid(ch, ok);
        vectors++;
        if (!ok || {ferr[ch], perr[ch], dout[ch]} !== e) begin
          miscompares++;
          $display("FAIL random ch%0d #%0d: got %0h (valid %0b) want %0h", ch, i,
                   {ferr[ch], perr[ch], dout[ch]}, ok, e);
        end
        pop(ch);
      end
    end
  endtask

  task automatic test_reset_mid;
    bit ok;
    int lat, vc;
    logic [9:0] w;
    logic bp;
    ready[0] = 1'b0;
    send_frame(0, 8'h5A, 1'b0, 2'b11);
    wait_valid(0, ok);
    line[0] = 1'b0;
    tick(OS);
    line[0] = 1'b1;
    tick(OS);
    line[0] = 1'b0;
    tick(OS / 2);
    vectors++;
    if (busy[0] !== 1'b1 || !ok) begin
      miscompares++;
      $display("FAIL reset_mid_setup: got busy %0b valid %0b want 1 1", busy[0], ok);
    end
    #2 rst_n = 1'b0;
    #1;
    vectors++;
    if ({dout[0], perr[0], ferr[0], valid[0], ovr[0], busy[0]} !== 13'd0) begin
      miscompares++;
      $display("FAIL reset_mid_outputs: got %0h want 0",
               {dout[0], perr[0], ferr[0], valid[0], ovr[0], busy[0]});
    end
    tick(2);
    line[0] = 1'b1;
    rst_n = 1'b1;
    tick(4);
    ready[0] = 1'b1;
    send_and_time(0, 8'hC3, 1'b0, 2'b11, lat, vc, w, bp);
    ready[0] = 1'b0;
    vectors++;
    if (w !== 10'h0C3 || vc !== 1 || lat !== lat_exp(0)) begin
      miscompares++;
      $display("FAIL reset_mid_next: got %0h cycles %0d lat %0d want 0c3 cycles 1 lat %0d",
               w, vc, lat, lat_exp(0));
    end
  endtask

  initial begin
    rst_n = 1'b0;
    line = 2'b11;
    ready = 2'b00;
    test_reset;
    test_clean_8n1;
    test_parity;
    test_false_start;
    test_frame_err;
    test_break;
    test_overrun;
    test_full_pop;
    test_back_to_back;
    test_random;
    test_reset_mid;
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #800000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1);
  end

endmodule
